// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// 8-bit sequencer for the cryptography processor. It owns a 256x8
// program/data memory, fetches and decodes one-byte opcodes, loads operand
// registers A and B from the instruction stream, and captures the external
// ALU result into register C. The host preloads memory through a manual
// write port, which also freezes the sequencer while active. The memory
// write bus is mirrored on the c_* bus outputs.
//
// Optional feature macro: CU_HALT_EN
//   defined   : opcode 0xF_ enters a HALT state left only by rst.
//   undefined : opcode 0xF_ behaves as a NOP; no HALT state exists.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   c_data_in    in   manual-load write data
//   c_addr_in    in   manual-load write address
//   manual_we    in   manual write enable, freezes the sequencer
//   alu_res_in   in   external ALU result (function of c_out_A/c_out_B)
//   c_data_out   out  memory bus data
//   c_addr_out   out  memory bus address
//   c_we         out  memory bus write strobe
//   c_out_A/B/C  out  operand registers A, B and result register C
// ---------------------------------------------------------------------------
module control_unit #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] c_data_in,
  input  logic [ADDR_W-1:0] c_addr_in,
  input  logic              manual_we,
  input  logic [DATA_W-1:0] alu_res_in,
  output logic [DATA_W-1:0] c_data_out,
  output logic [ADDR_W-1:0] c_addr_out,
  output logic              c_we,
  output logic [DATA_W-1:0] c_out_A,
  output logic [DATA_W-1:0] c_out_B,
  output logic [DATA_W-1:0] c_out_C
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC1,
`ifdef CU_HALT_EN
    S_HALT,
`endif
    S_EXEC2
  } state_t;

  localparam logic [3:0] OP_STI = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_LDB = 4'b0011;
  localparam logic [3:0] OP_ENC = 4'b0110;
`ifdef CU_HALT_EN
  localparam logic [3:0] OP_HLT = 4'b1111;
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  // Only the opcode nibble is kept: the low nibble of an instruction
  // never influences execution.
  logic [3:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] st_addr_q, st_addr_d;

  logic [DATA_W-1:0] mem_rd;
  logic [ADDR_W-1:0] pc_inc;
  logic              st_we;

  assign mem_rd = mem[pc_q];
  assign pc_inc = pc_q + 1'b1;   // natural wrap 255 -> 0

  // Next-state / datapath decode. Manual loading freezes everything.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    st_addr_d = st_addr_q;
    st_we     = 1'b0;

    if (!manual_we) begin
      unique case (state_q)
        S_FETCH: begin
          ir_d    = mem_rd[DATA_W-1 -: 4];
          pc_d    = pc_inc;
          state_d = S_EXEC1;
        end
        S_EXEC1: begin
          state_d = S_FETCH;
          case (ir_q)
            OP_STI: begin
              st_addr_d = mem_rd;
              pc_d      = pc_inc;
              state_d   = S_EXEC2;
            end
            OP_LDA: begin
              a_d  = mem_rd;
              pc_d = pc_inc;
            end
            OP_LDB: begin
              b_d  = mem_rd;
              pc_d = pc_inc;
            end
            OP_ENC: c_d = alu_res_in;
`ifdef CU_HALT_EN
            OP_HLT: state_d = S_HALT;
`endif
            default: ;  // NOP and unassigned opcodes
          endcase
        end
        S_EXEC2: begin
          st_we   = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
`ifdef CU_HALT_EN
        S_HALT: ;  // parked until rst
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      st_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      st_addr_q <= st_addr_d;
    end
  end

  // NOTE: the memory array is deliberately not reset; program contents
  // must survive rst, and a reset port would prevent RAM inference.
  // Manual writes ignore rst and win over an instruction store.
  always_ff @(posedge clk) begin
    if (manual_we)
      mem[c_addr_in] <= c_data_in;
    else if (st_we && !rst)
      mem[st_addr_q] <= mem_rd;
  end

  // Memory bus mirror.
  always_comb begin
    c_addr_out = pc_q;
    c_data_out = mem_rd;
    c_we       = 1'b0;
    if (manual_we) begin
      c_addr_out = c_addr_in;
      c_data_out = c_data_in;
      c_we       = 1'b1;
    end else if (state_q == S_EXEC2) begin
      c_addr_out = st_addr_q;
      c_we       = 1'b1;
    end
  end

  assign c_out_A = a_q;
  assign c_out_B = b_q;
  assign c_out_C = c_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Directed testbench for control_unit. Programs are loaded through the
// manual write port, the sequencer is reset and stepped edge by edge, and
// registers and bus outputs are compared with hand-computed values.
// The external ALU is modelled as A ^ B. Build with or without CU_HALT_EN.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] c_data_in;
  logic [7:0] c_addr_in;
  logic       manual_we;
  logic [7:0] alu_res_in;
  logic [7:0] c_data_out;
  logic [7:0] c_addr_out;
  logic       c_we;
  logic [7:0] c_out_A;
  logic [7:0] c_out_B;
  logic [7:0] c_out_C;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .c_data_in  (c_data_in),
    .c_addr_in  (c_addr_in),
    .manual_we  (manual_we),
    .alu_res_in (alu_res_in),
    .c_data_out (c_data_out),
    .c_addr_out (c_addr_out),
    .c_we       (c_we),
    .c_out_A    (c_out_A),
    .c_out_B    (c_out_B),
    .c_out_C    (c_out_C)
  );

  always #5 clk = ~clk;

  // External ALU model.
  assign alu_res_in = c_out_A ^ c_out_B;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] addr, input logic [7:0] data);
    manual_we = 1'b1;
    c_addr_in = addr;
    c_data_in = data;
    step(1);
    manual_we = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    manual_we = 1'b0;
    c_addr_in = '0;
    c_data_in = '0;
    step(2);
    rst = 1'b0;
    #1;

    // ---- Reset state ----
    check("rst_A", c_out_A, 8'h00);
    check("rst_B", c_out_B, 8'h00);
    check("rst_C", c_out_C, 8'h00);
    check("rst_pc", c_addr_out, 8'h00);
    check("rst_we", {7'b0, c_we}, 8'h00);

    // ---- Load program with bus mirror checks ----
    manual_we = 1'b1;
    c_addr_in = 8'h00;
    c_data_in = 8'h20;
    #1;
    check("load_we", {7'b0, c_we}, 8'h01);
    check("load_addr", c_addr_out, 8'h00);
    check("load_data", c_data_out, 8'h20);
    step(1);
    c_addr_in = 8'h01;
    c_data_in = 8'h1F;
    #1;
    check("load_addr1", c_addr_out, 8'h01);
    check("load_data1", c_data_out, 8'h1F);
    step(1);
    manual_we = 1'b0;
    load(8'h02, 8'h30);
    load(8'h03, 8'h34);
    load(8'h04, 8'h60);

    // ---- LDA / LDB / ENC ----
    reset_pulse();
    step(2);
    check("lda_A", c_out_A, 8'h1F);
    step(2);
    check("ldb_B", c_out_B, 8'h34);
    step(2);
    check("enc_C", c_out_C, 8'h2B);

    // ---- STI and readback by LDA at 0x09 ----
    load(8'h00, 8'h10);
    load(8'h01, 8'h0A);
    load(8'h02, 8'h63);
    for (int i = 3; i <= 8; i++) load(8'(i), 8'h00);
    load(8'h09, 8'h20);
    load(8'h0A, 8'h00);
    reset_pulse();
    step(2);
    check("sti_we", {7'b0, c_we}, 8'h01);
    check("sti_addr", c_addr_out, 8'h0A);
    check("sti_data", c_data_out, 8'h63);
    step(1);
    check("sti_we_off", {7'b0, c_we}, 8'h00);
    check("sti_pc", c_addr_out, 8'h03);
    step(14);
    check("sti_rb_A", c_out_A, 8'h63);
    check("sti_rb_pc", c_addr_out, 8'h0B);

    // ---- Reset during EXEC1 of an LDA ----
    load(8'h00, 8'h20);
    load(8'h01, 8'h1F);
    load(8'h02, 8'h20);
    load(8'h03, 8'h77);
    reset_pulse();
    step(3);
    check("mid_pc", c_addr_out, 8'h03);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    check("mid_A", c_out_A, 8'h00);
    check("mid_B", c_out_B, 8'h00);
    check("mid_C", c_out_C, 8'h00);
    check("mid_pc0", c_addr_out, 8'h00);
    step(2);
    check("mid_restart_A", c_out_A, 8'h1F);

    // ---- Freeze under manual_we ----
    load(8'h00, 8'h20);
    load(8'h01, 8'h1F);
    load(8'h02, 8'h30);
    load(8'h03, 8'h34);
    load(8'h04, 8'h60);
    reset_pulse();
    step(3);
    check("frz_pc_before", c_addr_out, 8'h03);
    manual_we = 1'b1;
    c_addr_in = 8'h80;
    c_data_in = 8'h99;
    #1;
    check("frz_bus_addr", c_addr_out, 8'h80);
    step(3);
    check("frz_A", c_out_A, 8'h1F);
    check("frz_B", c_out_B, 8'h00);
    manual_we = 1'b0;
    #1;
    check("frz_pc_held", c_addr_out, 8'h03);
    step(1);
    check("frz_resume_B", c_out_B, 8'h34);
    check("frz_resume_pc", c_addr_out, 8'h04);

    // ---- Unknown opcode 0x40 ----
    load(8'h00, 8'h40);
    load(8'h01, 8'h20);
    load(8'h02, 8'h55);
    reset_pulse();
    step(2);
    check("unk_A", c_out_A, 8'h00);
    check("unk_pc", c_addr_out, 8'h01);
    step(2);
    check("unk_lda_A", c_out_A, 8'h55);

    // ---- PC wrap on operand fetch: LDA at 0xFF, operand at 0x00 ----
    for (int i = 0; i < 256; i++)
      load(8'(i), (i == 0) ? 8'hAB : ((i == 255) ? 8'h20 : 8'h00));
    reset_pulse();
    step(511);
    check("wrap_pc0", c_addr_out, 8'h00);
    step(1);
    check("wrap_A", c_out_A, 8'hAB);
    check("wrap_pc1", c_addr_out, 8'h01);

    // ---- HLT opcode ----
    load(8'h00, 8'hF0);
    load(8'h01, 8'h20);
    load(8'h02, 8'h11);
    reset_pulse();
`ifdef CU_HALT_EN
    step(2);
    check("hlt_pc", c_addr_out, 8'h01);
    check("hlt_we", {7'b0, c_we}, 8'h00);
    step(10);
    check("hlt_A", c_out_A, 8'h00);
    check("hlt_pc_hold", c_addr_out, 8'h01);
    manual_we = 1'b1;
    c_addr_in = 8'h50;
    c_data_in = 8'h5A;
    #1;
    check("hlt_manual_we", {7'b0, c_we}, 8'h01);
    step(1);
    manual_we = 1'b0;
    step(4);
    check("hlt_A_after", c_out_A, 8'h00);
    check("hlt_pc_after", c_addr_out, 8'h01);
`else
    step(4);
    check("nohlt_A", c_out_A, 8'h11);
    check("nohlt_pc", c_addr_out, 8'h03);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- 8-bit sequencer for the cryptography processor: holds a 256x8 program/data memory, fetches and decodes instructions, and loads operand registers A and B.
- Captures the external ALU's encryption result into register C.
- The host preloads memory through a manual write port.
- The memory write bus is mirrored on outputs for external memory and peripherals.

Parameters:
- DATA_W, 8, data/instruction width (A, B, C, memory word).
- ADDR_W, 8, address width; PC width.
- MEM_DEPTH, 256, memory words (2**ADDR_W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- c_data_in  input  8  manual-load write data.
- c_addr_in  input  8  manual-load write address.
- manual_we  input  1  manual memory write enable; freezes the sequencer while high.
- alu_res_in  input  8  combinational result of the external ALU, computed from c_out_A and c_out_B.
- c_data_out  output  8  memory bus data.
- c_addr_out  output  8  memory bus address.
- c_we  output  1  memory bus write strobe.
- c_out_A  output  8  register A.
- c_out_B  output  8  register B.
- c_out_C  output  8  register C, the encryption result.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - PC=0, IR=0, A=B=C=0, state=FETCH, store-address latch=0.
  - Memory contents are NOT cleared.
- Memory:
  - Asynchronous read of mem[PC]; synchronous write.
  - If manual_we=1: mem[c_addr_in] <= c_data_in each clock. This applies regardless of rst, and has priority over an instruction store in the same cycle.
- Freeze: while manual_we=1 and rst=0, PC, state, IR and A/B/C hold.
- FSM states: FETCH, EXEC1, EXEC2, HALT.
  - FETCH: IR <= mem[PC], PC <= PC+1, go to EXEC1.
  - EXEC1, by IR[7:4]:
    - 0000 NOP: no effect, go to FETCH.
    - 0001 STI: addr latch <= mem[PC], PC+1, go to EXEC2.
    - 0010 LDA: A <= mem[PC], PC+1, go to FETCH.
    - 0011 LDB: B <= mem[PC], PC+1, go to FETCH.
    - 0110 ENC: C <= alu_res_in, go to FETCH.
    - 1111 HLT: see Optional Feature.
    - Any other opcode: treated as NOP, go to FETCH.
    - IR[3:0] is ignored.
  - EXEC2 (STI only): mem[addr latch] <= mem[PC], PC+1, go to FETCH.
  - HALT: holds all state until rst.
- Latencies:
  - NOP/LDA/LDB/ENC: 2 cycles each.
  - STI: 3 cycles.
  - Register update occurs on the clock edge ending EXEC1 (or EXEC2 for STI).
- PC arithmetic: PC wraps 255 -> 0, including on operand fetches.
- Bus outputs (combinational):
  - manual_we=1: c_addr_out=c_addr_in, c_data_out=c_data_in, c_we=1.
  - Else in EXEC2: c_addr_out=addr latch, c_data_out=mem[PC], c_we=1.
  - Otherwise: c_addr_out=PC, c_data_out=mem[PC], c_we=0.
- c_out_A/B/C are direct register outputs.
- Reset mid-instruction: the instruction is abandoned, and execution restarts at PC=0 on the next cycle.

Optional Feature:
- Macro CU_HALT_EN.
- Defined: opcode 1111 in EXEC1 moves the FSM to HALT. PC stops at (address of HLT)+1, and bus outputs show PC with c_we=0. Only rst leaves HALT; manual writes still work.
- Undefined: opcode 1111 executes as a NOP and there is no HALT state.

Test Plan:
- Load program via manual_we with rst=0: mem0=0x20, mem1=0x1F, mem2=0x30, mem3=0x34, mem4=0x60. Then rst pulse 1 cycle, with alu_res_in driven as c_out_A^c_out_B. Required: A=0x1F after the 2nd edge after reset release, B=0x34 after the 4th, C=0x2B after the 6th. During loading, c_we=1 and the bus mirrors the inputs.
- STI program 0x10,0x0A,0x63 with rst pulse. Required: on cycle 3, c_we=1, c_addr_out=0x0A, c_data_out=0x63. Afterwards mem[0x0A]=0x63, verified by an LDA from a program that reads it back.
- rst asserted during EXEC1 of an LDA. Required: A unchanged, PC=0, state FETCH on the next cycle; registers A/B/C=0 after reset.
- manual_we=1 mid-program. Required: PC and A/B/C frozen while high; execution resumes from the same PC when it drops.
- Unknown opcode 0x40 followed by 0x20,0x55. Required: 0x40 consumes 2 cycles with no effect, then A=0x55.
- With CU_HALT_EN: program 0xF0,0x20,0x11. Required: A stays 0 indefinitely and c_addr_out=1. Without the macro: A=0x11 after the 4th edge.
